// File: rtl/bcd_seg_scan.sv
// Multiplexed common-anode 4-digit 7-segment driver for a 3-digit BCD value, with frame-aligned shadow register.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero hundreds/tens digits.
module bcd_seg_scan #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] bcd,
   input  logic        load,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame
);
   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {IDLE, DIG0, DIG1, DIG2} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   pend_q, pend_d;
   logic [11:0]   disp_q, disp_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          frame_q, frame_d;
   logic          tick;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      case (n)
         4'd0:    dec7 = 7'b1000000;
         4'd1:    dec7 = 7'b1111001;
         4'd2:    dec7 = 7'b0100100;
         4'd3:    dec7 = 7'b0110000;
         4'd4:    dec7 = 7'b0011001;
         4'd5:    dec7 = 7'b0010010;
         4'd6:    dec7 = 7'b0000010;
         4'd7:    dec7 = 7'b1111000;
         4'd8:    dec7 = 7'b0000000;
         4'd9:    dec7 = 7'b0010000;
         default: dec7 = 7'b0111111;
      endcase
   endfunction

   assign tick  = (cnt_q == CW'(REFRESH_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      frame_d = 1'b0;
      disp_d  = disp_q;
      pend_d  = load ? bcd : pend_q;
      an_d    = 4'b1111;
      seg_d   = 7'b1111111;
      if (tick) begin
         case (state_q)
            IDLE:    begin state_d = DIG0; frame_d = 1'b1; end
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            DIG2:    begin state_d = DIG0; frame_d = 1'b1; end
            default: state_d = IDLE;
         endcase
      end
      // A load coinciding with the frame edge bypasses pend so it is not a frame late.
      if (frame_d) disp_d = load ? bcd : pend_q;
      // Outputs follow the next state so they switch on the same edge as the digit.
      case (state_d)
         DIG0: begin an_d = 4'b1110; seg_d = dec7(disp_d[3:0]); end
         DIG1: begin an_d = 4'b1101; seg_d = dec7(disp_d[7:4]); end
         DIG2: begin an_d = 4'b1011; seg_d = dec7(disp_d[11:8]); end
         default: ;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if ((state_d == DIG2 && disp_d[11:8] == 4'd0) ||
          (state_d == DIG1 && disp_d[11:8] == 4'd0 && disp_d[7:4] == 4'd0)) begin
         an_d  = 4'b1111;
         seg_d = 7'b1111111;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         disp_q  <= '0;
         an_q    <= 4'b1111;
         seg_q   <= 7'b1111111;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign frame = frame_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: randomized loads checked against a cycle-count based display model.
module tb_bcd_seg_scan;
   localparam int R = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] bcd = '0;
   logic        load = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame;

   typedef struct {
      int         k;
      logic [3:0] an;
      logic [6:0] seg;
      logic       frame;
   } exp_t;

   exp_t q[$];
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   int   k = 0;
   logic [11:0] m_pend = '0;
   logic [11:0] m_disp = '0;

   bcd_seg_scan #(.REFRESH_DIV(R)) dut (
      .clk(clk), .reset(reset), .bcd(bcd), .load(load),
      .an(an), .seg(seg), .frame(frame)
   );

   always #5 clk = ~clk;

   function automatic int digit_of(input int e);
      return (e < R) ? -1 : ((e / R) - 1) % 3;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return (n < 10) ? tbl[n] : 7'b0111111;
   endfunction

   task automatic check(input string name, input logic [3:0] a, input logic [6:0] s, input logic f,
                        input logic [3:0] ea, input logic [6:0] es, input logic ef);
      chk_cnt++;
      if (a === ea && s === es && f === ef) pass_cnt++;
      else $display("FAIL %s: got an=%b seg=%b frame=%b, want an=%b seg=%b frame=%b",
                    name, a, s, f, ea, es, ef);
   endtask

   // Called at a negedge: drive inputs for the coming edge, predict what follows it.
   task automatic cycle(input logic ld, input logic [11:0] b);
      exp_t e;
      int   d;
      logic [3:0] nib;
      load = ld;
      bcd  = b;
      k++;
      if (k % R == 0 && digit_of(k) == 0) m_disp = ld ? b : m_pend;
      if (ld) m_pend = b;
      d = digit_of(k);
      e.k = k;
      e.frame = (k % R == 0) && (d == 0);
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      if (d >= 0) begin
         nib = 4'((m_disp >> (4 * d)) & 12'hF);
         e.an = ~(4'b0001 << d);
         e.seg = glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
         if ((d == 2 && m_disp[11:8] == 0) || (d == 1 && m_disp[11:4] == 0)) begin
            e.an = 4'b1111;
            e.seg = 7'b1111111;
         end
`endif
      end
      q.push_back(e);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 12'($urandom));
   endtask

   // Monitor: the DUT presents a new display word after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("scan k=%0d", e.k), an, seg, frame, e.an, e.seg, e.frame);
         end
      end
   end

   initial begin
      logic [11:0] v;
      repeat (2) @(negedge clk);
      check("reset_state", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
      reset = 1'b0;
      k = 0; m_pend = '0; m_disp = '0;
      idle(20);

      while (!(digit_of(k + 1) == 1 && (k + 1) % R == 2)) idle(1);
      cycle(1'b1, 12'h255);
      idle(30);

      while (!((k + 1) % R == 0 && digit_of(k + 1) == 0)) idle(1);
      cycle(1'b1, 12'h128);
      idle(15);

      cycle(1'b1, 12'h0A7);
      idle(40);
      cycle(1'b1, 12'h007);
      idle(40);
      cycle(1'b1, 12'h000);
      idle(30);

      for (int i = 0; i < 1500; i++) begin
         v = 12'($urandom);
         if ($urandom_range(1, 0) == 1) v = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
         cycle($urandom_range(3, 0) == 0, v);
      end

      // Asynchronous reset landing mid-DIG1.
      while (!(digit_of(k) == 1 && k % R == 2)) idle(1);
      #2 reset = 1'b1;
      #1 check("async_reset", an, seg, frame, 4'b1111, 7'b1111111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      k = 0; m_pend = '0; m_disp = '0;
      idle(20);
      for (int i = 0; i < 200; i++) cycle($urandom_range(2, 0) == 0, 12'($urandom));
      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed 7-segment display driver for the 12-bit BCD value produced by the binary-to-BCD converter. It sits directly downstream of that converter and drives a common-anode 4-digit display. Three digits show hundreds/tens/ones, and the fourth digit is held dark. A shadow register updates the displayed value only at frame boundaries, so a digit never shows a mix of old and new values within one scan.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays lit. Legal range is ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- bcd  in  12  BCD value: [11:8] hundreds, [7:4] tens, [3:0] ones.
- load  in  1  on a cycle where load=1, capture bcd into the pending register.
- an  out  4  anode enables, active-low; an[0] is ones, an[2] is hundreds, an[3] is always 1.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- frame  out  1  one-cycle pulse on the edge where the display register is loaded.

## Operation
- Prescaler cnt, width $clog2(REFRESH_DIV):
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
- Pending register pend[11:0] <= bcd on any cycle with load=1.
- FSM states: IDLE, DIG0, DIG1, DIG2. State changes only when tick=1.
  - IDLE -> DIG0
  - DIG0 -> DIG1
  - DIG1 -> DIG2
  - DIG2 -> DIG0
- Frame boundary is the tick edge taken from IDLE or from DIG2. On that edge:
  - disp <= (load ? bcd : pend), i.e. a simultaneous load bypasses pend.
  - frame = 1 for exactly that cycle.
- Digit selected by state: DIG0 shows disp[3:0] with an=1110; DIG1 shows disp[7:4] with an=1101; DIG2 shows disp[11:8] with an=1011.
- Segment decode, nibble -> seg:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001
  - 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000
  - 10-15 (invalid BCD) -> 0111111, a dash (g segment only).
- an and seg are registered and are computed from the next-state and next-disp values. They therefore change on the same edge as the state.
- In IDLE: an=1111, seg=1111111.

## Timing
- Reset values:
  - cnt=0, state=IDLE, pend=0, disp=0, an=1111, seg=1111111, frame=0.
- After reset release, the first tick occurs on the REFRESH_DIV-th rising edge. On that edge:
  - an=1110
  - seg shows the ones digit of pend, or of bcd if load=1 on that cycle.
  - frame=1
- Each digit is lit for exactly REFRESH_DIV cycles. A full frame is 3*REFRESH_DIV cycles.
- Load-to-display latency is at most 3*REFRESH_DIV cycles. A new value appears starting with the ones digit at the next frame boundary.
- A load between frame boundaries never alters disp mid-frame.
- Multiple loads within one frame: only the last one is displayed.
- An asserted reset immediately (asynchronously) forces all reset values; scanning restarts from IDLE.

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During DIG2, if disp[11:8]==0, force an=1111 and seg=1111111.
  - During DIG1, if disp[11:8]==0 and disp[7:4]==0, force the same blank.
  - Ones is never blanked.
  - State sequencing and timing are unchanged.
- Undefined: all three digits are always lit, so zeros show as 1000000.

## Test plan
- REFRESH_DIV=4, reset then release, no load -> an=1111 for 3 edges; 4th edge gives an=1110, seg=1000000, frame=1.
- load=1 with bcd=12'h255 in mid-DIG1 -> the current frame is unchanged. From the next frame boundary:
  - DIG0: seg=0010010
  - DIG1: seg=0010010
  - DIG2: seg=0100100
  - Each digit lasts 4 cycles.
- load=1 with bcd=12'h128 on the exact DIG2->DIG0 tick cycle -> bypass takes effect on that edge: DIG0 shows 0000000 ("8").
- bcd=12'h0A7 loaded -> ones=1111000, tens=0111111 (dash), hundreds=1000000, or blank with LEADING_ZERO_BLANK_EN.
- With LEADING_ZERO_BLANK_EN and bcd=12'h007 -> DIG1 and DIG2 both give an=1111, seg=1111111; DIG0 gives an=1110, seg=1111000.
- Assert reset during DIG1 -> an=1111, seg=1111111, frame=0 with no clock edge. After release, the first digit appears after 4 cycles and shows 0, since pend was cleared.
